// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus: memory controller request/response, IQ head, ROB flush.
interface inst_fetcher_if;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_inst;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_jump;
  logic        issue_ready;
  logic        rollback;
  logic [31:0] rollback_pc;

  modport master (
    output mc_req, mc_addr,
    input  mc_done, mc_inst,
    output iq_valid, iq_inst, iq_pc, iq_pred_jump,
    input  issue_ready, rollback, rollback_pc
  );

  modport slave (
    input  mc_req, mc_addr,
    output mc_done, mc_inst,
    input  iq_valid, iq_inst, iq_pc, iq_pred_jump,
    output issue_ready, rollback, rollback_pc
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch with show-ahead instruction queue,
// static JAL redirect and ROB rollback flush.
module inst_fetcher #(
  parameter int IQ_DEPTH = 8,
  parameter int IQ_AW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  inst_fetcher_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc, pc_nx;
  logic        req, req_nx;
  logic [31:0] addr, addr_nx;

  logic [31:0] q_pc   [IQ_DEPTH];
  logic [31:0] q_inst [IQ_DEPTH];
  logic        q_pj   [IQ_DEPTH];

  logic [IQ_AW-1:0] head, tail;
  logic [IQ_AW:0]   count;

  logic        valid, full;
  logic        push, pop, flush;
  logic        jal;
  logic [31:0] jimm;

  assign flush = bus.rollback;
  assign valid = (count != '0);
  assign full  = (count == (IQ_AW+1)'(IQ_DEPTH));
  assign pop   = valid && bus.issue_ready && !flush;

  assign jal  = (bus.mc_inst[6:0] == 7'b1101111);
  assign jimm = {{12{bus.mc_inst[31]}},
                 bus.mc_inst[19:12],
                 bus.mc_inst[20],
                 bus.mc_inst[30:21],
                 1'b0};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    req_nx   = req;
    addr_nx  = addr;
    push     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush && !full) begin
          state_nx = WAIT;
          req_nx   = 1'b1;
          addr_nx  = pc;
        end
      end
      WAIT: begin
        if (bus.mc_done) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          if (!flush) begin
            push  = 1'b1;
            pc_nx = jal ? pc + jimm : pc + 32'd4;
          end
        end else if (flush) begin
          state_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.mc_done) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // restart pc wins over any fall-through or redirect
    if (flush) pc_nx = bus.rollback_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      req   <= 1'b0;
      addr  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      state <= state_nx;
      pc    <= pc_nx;
      req   <= req_nx;
      addr  <= addr_nx;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + IQ_AW'(1);
        if (pop)  head <= head + IQ_AW'(1);
        if (push && !pop)
          count <= count + (IQ_AW+1)'(1);
        else if (pop && !push)
          count <= count - (IQ_AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && push) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= bus.mc_inst;
      q_pj[tail]   <= jal;
    end
  end

  assign bus.mc_req       = req;
  assign bus.mc_addr      = addr;
  assign bus.iq_valid     = valid;
  assign bus.iq_pc        = valid ? q_pc[head]   : '0;
  assign bus.iq_inst      = valid ? q_inst[head] : '0;
  assign bus.iq_pred_jump = valid ? q_pj[head]   : 1'b0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: queue-level model checked every cycle,
// plus literal address/pc sequences for each scenario.
module tb_inst_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  inst_fetcher_if bus();

  inst_fetcher #(.IQ_DEPTH(8), .IQ_AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // memory image: addi everywhere except two JALs
  logic [31:0] memw [logic [31:0]];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return memw.exists(a) ? memw[a] : 32'h0000_0013;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pj;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_addr = '0;
  logic        m_req = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_drop = 1'b0;
  int          m_sz;

  function automatic logic [31:0] next_pc(logic [31:0] p, logic [31:0] i);
    logic [20:0] off;
    off = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    if (i[6:0] == 7'h6F) return p + {{11{off[20]}}, off};
    return p + 32'd4;
  endfunction

  always @(posedge clk) begin
    m_sz = m_q.size();
    if (rst) begin
      m_q.delete();
      m_pc   = '0;
      m_addr = '0;
      m_req  = 1'b0;
      m_busy = 1'b0;
      m_drop = 1'b0;
    end else if (rdy) begin
      if (bus.rollback) begin
        m_q.delete();
        m_pc = bus.rollback_pc;
        if (m_busy && bus.mc_done) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
          m_req  = 1'b0;
        end else if (m_busy) begin
          m_drop = 1'b1;
        end
      end else begin
        if (m_sz > 0 && bus.issue_ready) void'(m_q.pop_front());
        if (m_busy) begin
          if (bus.mc_done) begin
            if (!m_drop) begin
              m_q.push_back('{pc: m_pc, inst: bus.mc_inst,
                              pj: (bus.mc_inst[6:0] == 7'h6F)});
              m_pc = next_pc(m_pc, bus.mc_inst);
            end
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_req  = 1'b0;
          end
        end else if (m_sz < 8) begin
          m_busy = 1'b1;
          m_req  = 1'b1;
          m_addr = m_pc;
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mc_req", 32'(bus.mc_req), 32'(m_req));
      chk("mc_addr", bus.mc_addr, m_addr);
      chk("iq_valid", 32'(bus.iq_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("iq_pc", bus.iq_pc, m_q[0].pc);
        chk("iq_inst", bus.iq_inst, m_q[0].inst);
        chk("iq_pj", 32'(bus.iq_pred_jump), 32'(m_q[0].pj));
      end else begin
        chk("iq_pc_empty", bus.iq_pc, 32'h0);
        chk("iq_inst_empty", bus.iq_inst, 32'h0);
        chk("iq_pj_empty", 32'(bus.iq_pred_jump), 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  int          w = 0;
  int          lat = 2;
  bit          auto_mem = 1'b1;
  logic [31:0] addr_log[$];
  logic [31:0] pop_pc[$];
  logic        pop_pj[$];

  logic [31:0] exp_a [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                             32'h20, 32'h18, 32'h1C, 32'h20};
  logic        exp_pj[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic next_cycle();
    if (rdy && !rst && !bus.rollback && bus.iq_valid === 1'b1 &&
        bus.issue_ready) begin
      pop_pc.push_back(bus.iq_pc);
      pop_pj.push_back(bus.iq_pred_jump);
    end
    @(negedge clk);
    if (bus.mc_req === 1'b1) begin
      w++;
      if (w == 1) addr_log.push_back(bus.mc_addr);
    end else begin
      w = 0;
    end
    if (auto_mem) begin
      bus.mc_done = (bus.mc_req === 1'b1) && (w == lat);
      bus.mc_inst = bus.mc_done ? mem_word(bus.mc_addr) : 32'h0;
    end
  endtask

  function automatic logic [31:0] last_addr();
    return (addr_log.size() > 0) ? addr_log[addr_log.size()-1] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int a0;
    logic [31:0] s_addr;
    logic [31:0] s_pc;

    bus.mc_done     = 1'b0;
    bus.mc_inst     = 32'h0;
    bus.issue_ready = 1'b0;
    bus.rollback    = 1'b0;
    bus.rollback_pc = 32'h0;
    memw[32'h10] = 32'h0100_006F;
    memw[32'h20] = 32'hFF9F_F06F;

    // reset
    @(negedge clk);
    cmp_en = 1'b1;
    next_cycle();
    chk("rst_req", 32'(bus.mc_req), 32'h0);
    chk("rst_addr", bus.mc_addr, 32'h0);
    chk("rst_valid", 32'(bus.iq_valid), 32'h0);
    chk("rst_pc", bus.iq_pc, 32'h0);

    // stream with JAL redirects at 0x10 and 0x20
    rst = 1'b0;
    bus.issue_ready = 1'b1;
    repeat (36) next_cycle();
    for (int i = 0; i < 9; i++)
      chk("addr_seq", (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF,
          exp_a[i]);
    for (int i = 0; i < 7; i++) begin
      chk("pop_pc_seq", (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF,
          exp_a[i]);
      chk("pop_pj_seq", (i < pop_pj.size()) ? 32'(pop_pj[i]) : 32'hDEAD_BEEF,
          32'(exp_pj[i]));
    end

    // fill the queue
    bus.issue_ready = 1'b0;
    bus.rollback    = 1'b1;
    bus.rollback_pc = 32'h40;
    next_cycle();
    bus.rollback = 1'b0;
    pop_pc.delete();
    a0 = addr_log.size();
    repeat (40) next_cycle();
    chk("full_reqs", 32'(addr_log.size() - a0), 32'd8);
    chk("full_req_low", 32'(bus.mc_req), 32'h0);
    chk("full_head", bus.iq_pc, 32'h40);

    // one pop lets exactly one request out
    bus.issue_ready = 1'b1;
    next_cycle();
    bus.issue_ready = 1'b0;
    a0 = addr_log.size();
    repeat (10) next_cycle();
    chk("refill_reqs", 32'(addr_log.size() - a0), 32'd1);
    chk("refill_addr", last_addr(), 32'h60);
    chk("refill_req_low", 32'(bus.mc_req), 32'h0);

    // push and pop together at count 7
    bus.issue_ready = 1'b1;
    next_cycle();
    bus.issue_ready = 1'b0;
    g = 0;
    while (bus.mc_done !== 1'b1 && g < 10) begin
      next_cycle();
      g++;
    end
    chk("pp_done_seen", 32'(g < 10), 32'h1);
    bus.issue_ready = 1'b1;
    next_cycle();
    bus.issue_ready = 1'b0;
    chk("pp_head", bus.iq_pc, 32'h4C);

    // drain: order must be contiguous from 0x40
    bus.issue_ready = 1'b1;
    repeat (30) next_cycle();
    for (int i = 0; i < 12; i++)
      chk("drain_order", (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF,
          32'h40 + 32'(4 * i));

    // rollback while a request is outstanding, 3 entries queued
    bus.issue_ready = 1'b0;
    g = 0;
    while (!(m_q.size() == 3 && bus.mc_req === 1'b1 && w == 1) && g < 60) begin
      next_cycle();
      g++;
    end
    chk("rb_setup", 32'(g < 60), 32'h1);
    bus.rollback    = 1'b1;
    bus.rollback_pc = 32'h100;
    next_cycle();
    bus.rollback = 1'b0;
    chk("rb_valid", 32'(bus.iq_valid), 32'h0);
    chk("rb_req_held", 32'(bus.mc_req), 32'h1);
    a0 = addr_log.size();
    g = 0;
    while (addr_log.size() == a0 && g < 10) begin
      next_cycle();
      g++;
    end
    chk("rb_addr", last_addr(), 32'h100);
    chk("rb_dropped", 32'(bus.iq_valid), 32'h0);

    // rollback coincident with mc_done
    g = 0;
    while (!(bus.mc_done === 1'b1 && m_q.size() >= 1) && g < 30) begin
      next_cycle();
      g++;
    end
    chk("rb2_setup", 32'(g < 30), 32'h1);
    bus.rollback    = 1'b1;
    bus.rollback_pc = 32'h200;
    next_cycle();
    bus.rollback = 1'b0;
    chk("rb2_valid", 32'(bus.iq_valid), 32'h0);
    chk("rb2_req_low", 32'(bus.mc_req), 32'h0);
    a0 = addr_log.size();
    g = 0;
    while (addr_log.size() == a0 && g < 10) begin
      next_cycle();
      g++;
    end
    chk("rb2_addr", last_addr(), 32'h200);
    chk("rb2_dropped", 32'(bus.iq_valid), 32'h0);

    // rdy stall in WAIT with two entries queued
    g = 0;
    while (!(m_q.size() == 2 && bus.mc_req === 1'b1 && w == 1) && g < 40) begin
      next_cycle();
      g++;
    end
    chk("stall_setup", 32'(g < 40), 32'h1);
    auto_mem = 1'b0;
    s_addr = bus.mc_addr;
    s_pc   = bus.iq_pc;
    chk("stall_head_pos", s_pc, s_addr - 32'd8);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mc_done     = (i % 2 == 0);
      bus.mc_inst     = 32'h0000_006F;
      bus.issue_ready = 1'b1;
      next_cycle();
      chk("stall_req", 32'(bus.mc_req), 32'h1);
      chk("stall_addr", bus.mc_addr, s_addr);
      chk("stall_pc", bus.iq_pc, s_pc);
    end
    rdy = 1'b1;
    bus.mc_done = 1'b0;
    bus.mc_inst = 32'h0;
    w = 1;
    auto_mem = 1'b1;
    pop_pc.delete();
    a0 = addr_log.size();
    repeat (20) next_cycle();
    chk("resume_addr", (a0 < addr_log.size()) ? addr_log[a0] : 32'hDEAD_BEEF,
        s_addr + 32'd4);
    for (int i = 0; i < 5; i++)
      chk("resume_order", (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF,
          s_addr - 32'd8 + 32'(4 * i));

    // reset beats rdy=0
    rdy = 1'b0;
    rst = 1'b1;
    next_cycle();
    chk("rst_prio_req", 32'(bus.mc_req), 32'h0);
    chk("rst_prio_valid", 32'(bus.iq_valid), 32'h0);
    chk("rst_prio_addr", bus.mc_addr, 32'h0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
